// File: rtl/ev_tag_compare_pkg.sv
// Shared EV/PP definitions: default widths, FSM state encoding and verdict codes
// used by the EV tag comparison stage.
package ev_tag_compare_pkg;

    localparam int EV_HASHTAG_WIDTH_DEF  = 64;
    localparam int FRAME_ROUND_WIDTH_DEF = 6;
    localparam int TIMEOUT_CYCLES_DEF    = 65535;
    localparam int EV_CNT_WIDTH          = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_COMPARE = 2'b10,
        ST_SEND    = 2'b11
    } ev_state_t;

    typedef enum logic [1:0] {
        RES_PASS           = 2'b00,
        RES_TAG_MISMATCH   = 2'b01,
        RES_ROUND_MISMATCH = 2'b10,
        RES_TIMEOUT        = 2'b11
    } ev_result_t;

    // Verdict counters stick at all-ones instead of wrapping.
    function automatic logic [EV_CNT_WIDTH-1:0] sat_inc(input logic [EV_CNT_WIDTH-1:0] value);
        return (value == {EV_CNT_WIDTH{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/ev_tag_compare.sv
// Compares Bob's EV hash tag with the tag received from Alice and hands a
// pass / mismatch / timeout verdict to the Alice-side transmitter.
module ev_tag_compare
    import ev_tag_compare_pkg::*;
#(
    parameter int EV_HASHTAG_WIDTH  = EV_HASHTAG_WIDTH_DEF,
    parameter int FRAME_ROUND_WIDTH = FRAME_ROUND_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES    = TIMEOUT_CYCLES_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [EV_HASHTAG_WIDTH-1:0]  target_hashtag,
    input  logic                         hashtag_valid,
    input  logic [FRAME_ROUND_WIDTH-1:0] frame_round,
    input  logic [EV_HASHTAG_WIDTH-1:0]  alice_tag,
    input  logic [FRAME_ROUND_WIDTH-1:0] alice_round,
    input  logic                         alice_tag_valid,
    output logic                         alice_tag_ready,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic [1:0]                   result_code,
    output logic [FRAME_ROUND_WIDTH-1:0] result_round,
    output logic                         ev_done,
    output logic                         ev_pass,
    output logic [EV_CNT_WIDTH-1:0]      pass_cnt,
    output logic [EV_CNT_WIDTH-1:0]      fail_cnt,
    output logic                         overrun_err
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    ev_state_t                    state;
    ev_state_t                    state_next;
    logic                         have_local;
    logic                         have_alice;
    logic [EV_HASHTAG_WIDTH-1:0]  local_tag;
    logic [FRAME_ROUND_WIDTH-1:0] local_round;
    logic [EV_HASHTAG_WIDTH-1:0]  alice_tag_q;
    logic [FRAME_ROUND_WIDTH-1:0] alice_round_q;
    logic [TW-1:0]                timeout_cnt;
    ev_result_t                   result_code_q;
    ev_result_t                   compare_code;

    logic in_window;
    logic cap_local;
    logic cap_alice;
    logic send_done;
    logic go_timeout;

    // rst_n is active-high; the handshake outputs are masked while it is held.
    assign in_window       = (state == ST_IDLE) || (state == ST_COLLECT);
    assign cap_local       = in_window && hashtag_valid && !have_local;
    assign alice_tag_ready = in_window && !have_alice && !rst_n;
    assign cap_alice       = alice_tag_valid && alice_tag_ready;
    assign result_valid    = (state == ST_SEND) && !rst_n;
    assign send_done       = result_valid && result_ready;
    assign go_timeout      = (state == ST_COLLECT) && !(have_local && have_alice)
                             && (timeout_cnt == TW'(TIMEOUT_CYCLES));
    assign result_code     = result_code_q;

    always_comb begin
        compare_code = RES_PASS;
        if (local_round != alice_round_q) begin
            compare_code = RES_ROUND_MISMATCH;
        end else if (local_tag != alice_tag_q) begin
            compare_code = RES_TAG_MISMATCH;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if ((have_local || cap_local) && (have_alice || cap_alice)) begin
                    state_next = ST_COMPARE;
                end else if (cap_local || cap_alice) begin
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (have_local && have_alice) begin
                    state_next = ST_COMPARE;
                end else if (go_timeout) begin
                    state_next = ST_SEND;
                end
            end
            ST_COMPARE: state_next = ST_SEND;
            ST_SEND: begin
                if (result_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state          <= ST_IDLE;
            have_local     <= 1'b0;
            have_alice     <= 1'b0;
            local_tag      <= '0;
            local_round    <= '0;
            alice_tag_q    <= '0;
            alice_round_q  <= '0;
            timeout_cnt    <= '0;
            result_code_q  <= RES_PASS;
            result_round   <= '0;
            ev_done        <= 1'b0;
            ev_pass        <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            overrun_err    <= 1'b0;
        end else begin
            state   <= state_next;
            ev_done <= 1'b0;

            if (cap_local) begin
                local_tag   <= target_hashtag;
                local_round <= frame_round;
                have_local  <= 1'b1;
            end
            if (hashtag_valid && have_local) begin
                overrun_err <= 1'b1;
            end
            if (cap_alice) begin
                alice_tag_q   <= alice_tag;
                alice_round_q <= alice_round;
                have_alice    <= 1'b1;
            end

            // Counter idles at zero outside COLLECT, so it is already clear on entry.
            if (state != ST_COLLECT) begin
                timeout_cnt <= '0;
            end else if (!go_timeout) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end

            if (state == ST_COMPARE) begin
                result_code_q <= compare_code;
                result_round  <= local_round;
            end else if (go_timeout) begin
                result_code_q <= RES_TIMEOUT;
                result_round  <= have_local ? local_round : alice_round_q;
            end

            if (send_done) begin
                ev_done    <= 1'b1;
                ev_pass    <= (result_code_q == RES_PASS);
                have_local <= 1'b0;
                have_alice <= 1'b0;
                if (result_code_q == RES_PASS) begin
                    pass_cnt <= sat_inc(pass_cnt);
                end else begin
                    fail_cnt <= sat_inc(fail_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_ev_tag_compare.sv
// Directed scoreboard bench for ev_tag_compare: in-order, reversed and simultaneous
// arrival, timeouts, backpressure, overrun, reset abort and counter saturation.
module tb_ev_tag_compare;
    import ev_tag_compare_pkg::*;

    localparam int EVW = 64;
    localparam int FRW = 6;
    localparam int TO  = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [EVW-1:0] target_hashtag = '0;
    logic           hashtag_valid = 1'b0;
    logic [FRW-1:0] frame_round = '0;
    logic [EVW-1:0] alice_tag = '0;
    logic [FRW-1:0] alice_round = '0;
    logic           alice_tag_valid = 1'b0;
    logic           alice_tag_ready;
    logic           result_valid;
    logic           result_ready = 1'b0;
    logic [1:0]     result_code;
    logic [FRW-1:0] result_round;
    logic           ev_done;
    logic           ev_pass;
    logic [15:0]    pass_cnt;
    logic [15:0]    fail_cnt;
    logic           overrun_err;

    ev_tag_compare #(
        .EV_HASHTAG_WIDTH (EVW),
        .FRAME_ROUND_WIDTH(FRW),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .target_hashtag (target_hashtag),
        .hashtag_valid  (hashtag_valid),
        .frame_round    (frame_round),
        .alice_tag      (alice_tag),
        .alice_round    (alice_round),
        .alice_tag_valid(alice_tag_valid),
        .alice_tag_ready(alice_tag_ready),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_code    (result_code),
        .result_round   (result_round),
        .ev_done        (ev_done),
        .ev_pass        (ev_pass),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .overrun_err    (overrun_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]     code;
        logic [FRW-1:0] round;
    } exp_t;

    exp_t        exp_q[$];
    int          num_checks = 0;
    int          num_passed = 0;
    int          num_failed = 0;
    logic [15:0] model_pass = '0;
    logic [15:0] model_fail = '0;

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
    endfunction

    function automatic exp_t modelVerdict(input logic [EVW-1:0] lt, input logic [FRW-1:0] lr,
                                          input logic [EVW-1:0] at, input logic [FRW-1:0] ar);
        exp_t e;
        e.round = lr;
        if (lr != ar)      e.code = RES_ROUND_MISMATCH;
        else if (lt != at) e.code = RES_TAG_MISMATCH;
        else               e.code = RES_PASS;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        num_checks++;
        assert (observed === expected) num_passed++;
        else begin
            num_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
        end
    endtask

    // Offers a local tag and/or an Alice tag for exactly one clock.
    task automatic applyStimulus(input logic do_local, input logic [EVW-1:0] lt, input logic [FRW-1:0] lr,
                                 input logic do_alice, input logic [EVW-1:0] at, input logic [FRW-1:0] ar);
        if (do_alice) checkOutput("alice_ready", alice_tag_ready, 1);
        target_hashtag  = lt;
        frame_round     = lr;
        hashtag_valid   = do_local;
        alice_tag       = at;
        alice_round     = ar;
        alice_tag_valid = do_alice;
        tick();
        hashtag_valid   = 1'b0;
        alice_tag_valid = 1'b0;
    endtask

    task automatic waitResult(input int max_cycles, input string name, output int n);
        n = 0;
        while (result_valid !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        checkOutput({name, "_valid"}, result_valid, 1);
    endtask

    task automatic checkResult(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            num_checks++;
            num_failed++;
            $error("[TB] FAIL %s_queue: observed verdict with no expected entry", name);
            return;
        end
        e = exp_q.pop_front();
        checkOutput({name, "_code"}, result_code, e.code);
        checkOutput({name, "_round"}, result_round, e.round);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        if (e.code == RES_PASS) model_pass = sat16(model_pass);
        else                    model_fail = sat16(model_fail);
        checkOutput({name, "_done"}, ev_done, 1);
        checkOutput({name, "_pass"}, ev_pass, (e.code == RES_PASS));
        checkOutput({name, "_pass_cnt"}, pass_cnt, model_pass);
        checkOutput({name, "_fail_cnt"}, fail_cnt, model_fail);
        checkOutput({name, "_valid_low"}, result_valid, 0);
        tick();
        checkOutput({name, "_done_low"}, ev_done, 0);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   n;
        exp_t e;
        logic [EVW-1:0] tag_a;

        repeat (3) tick();
        checkOutput("reset_outputs",
                    {alice_tag_ready, result_valid, result_code, result_round, ev_done, ev_pass,
                     pass_cnt, fail_cnt, overrun_err}, 0);
        rst_n = 1'b0;
        tick();
        checkOutput("idle_ready", alice_tag_ready, 1);

        // Local first, equal Alice tag three cycles later.
        tag_a = 64'h0123456789ABCDEF;
        exp_q.push_back(modelVerdict(tag_a, 6'd5, tag_a, 6'd5));
        applyStimulus(1, tag_a, 6'd5, 0, '0, '0);
        tick();
        tick();
        applyStimulus(0, '0, '0, 1, tag_a, 6'd5);
        checkOutput("t1_lat0", result_valid, 0);
        tick();
        checkOutput("t1_lat1", result_valid, 0);
        tick();
        checkOutput("t1_lat2", result_valid, 1);
        checkResult("t1");

        // Alice first, tags differ in the LSB only.
        exp_q.push_back(modelVerdict({64{1'b1}} - 64'd1, 6'd2, {64{1'b1}}, 6'd2));
        applyStimulus(0, '0, '0, 1, {64{1'b1}}, 6'd2);
        applyStimulus(1, {64{1'b1}} - 64'd1, 6'd2, 0, '0, '0);
        checkOutput("t2_lat0", result_valid, 0);
        tick();
        checkOutput("t2_lat1", result_valid, 0);
        tick();
        checkOutput("t2_lat2", result_valid, 1);
        checkResult("t2");

        // Both tags in the same cycle with differing rounds.
        tag_a = 64'hDEADBEEF_CAFEF00D;
        exp_q.push_back(modelVerdict(tag_a, 6'd3, tag_a, 6'd4));
        applyStimulus(1, tag_a, 6'd3, 1, tag_a, 6'd4);
        waitResult(4, "t3", n);
        checkResult("t3");

        // Local-only timeout, then Alice-only timeout.
        exp_q.push_back('{code: RES_TIMEOUT, round: 6'd7});
        applyStimulus(1, 64'h1111, 6'd7, 0, '0, '0);
        waitResult(40, "t4", n);
        checkOutput("t4_latency", n, 17);
        checkResult("t4");

        exp_q.push_back('{code: RES_TIMEOUT, round: 6'd9});
        applyStimulus(0, '0, '0, 1, 64'h2222, 6'd9);
        waitResult(40, "t5", n);
        checkOutput("t5_latency", n, 17);
        checkResult("t5");

        // Overrun in COLLECT, backpressure in SEND, then reset abort.
        checkOutput("overrun_clear", overrun_err, 0);
        tag_a = 64'h0F0F_0F0F_0F0F_0F0F;
        exp_q.push_back(modelVerdict(tag_a, 6'd1, tag_a, 6'd1));
        applyStimulus(1, tag_a, 6'd1, 0, '0, '0);
        applyStimulus(1, 64'h5555, 6'd2, 0, '0, '0);
        checkOutput("overrun_set", overrun_err, 1);
        applyStimulus(0, '0, '0, 1, tag_a, 6'd1);
        waitResult(4, "t6", n);
        e = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_hold", {result_valid, result_code, result_round}, {1'b1, e.code, e.round});
            tick();
        end
        checkOutput("bp_overrun", overrun_err, 1);
        result_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        checkOutput("rst_ready_low", alice_tag_ready, 0);
        tick();
        checkOutput("rst_abort_outputs",
                    {alice_tag_ready, result_valid, result_code, result_round, ev_done, ev_pass,
                     pass_cnt, fail_cnt, overrun_err}, 0);
        tick();
        checkOutput("rst_no_done", ev_done, 0);
        rst_n = 1'b0;
        result_ready = 1'b0;
        exp_q.delete();
        model_pass = '0;
        model_fail = '0;
        tick();
        checkOutput("rst_release_cnt", {pass_cnt, fail_cnt}, 0);

        // Saturation: preload fail_cnt near the top, then keep failing.
        force dut.fail_cnt = 16'hFFFD;
        tick();
        release dut.fail_cnt;
        model_fail = 16'hFFFD;
        for (int i = 0; i < 3; i++) begin
            tag_a = 64'hA5A5_0000 + 64'(i);
            exp_q.push_back(modelVerdict(tag_a, 6'd4, ~tag_a, 6'd4));
            applyStimulus(1, tag_a, 6'd4, 1, ~tag_a, 6'd4);
            waitResult(4, "sat", n);
            checkResult("sat");
        end
        checkOutput("sat_final", fail_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", num_passed, num_checks);
        $finish;
    end

endmodule
